// File: rtl/turf_reg_bridge.sv
// Command-stream to register-bus master: one bus access per command, bounded ack wait, one response per command.
// Optional statistics counters on stat_o are compiled in when TURF_BRIDGE_STATS_EN is defined.
module turf_reg_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [27:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [7:0]  cmd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [7:0]  rsp_tag,
  output logic        rsp_err,
  output logic        en_o,
  output logic        wr_o,
  output logic [27:0] adr_o,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic [31:0] stat_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} state_t;

  // Counter value seen in the last permitted en_o cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic        wr_q, wr_d;
  logic [27:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  tag_q, tag_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    wr_d        = wr_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          en_d    = 1'b1;
          wr_d    = cmd_wr;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          tag_d   = cmd_tag;
          cnt_d   = 16'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // An ack in the final permitted cycle still completes normally.
        if (ack_i) begin
          en_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_dat_d   = wr_q ? dat_q : dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else if (cnt_q == TO_LAST) begin
          en_d        = 1'b0;
          rsp_dat_d   = ERR_DATA;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      wr_q        <= wr_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Held low while rst is asserted so no command is taken during reset.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = rsp_err_q;
  assign en_o      = en_q;
  assign wr_o      = wr_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;

`ifdef TURF_BRIDGE_STATS_EN
  logic [15:0] stat_ack_q, stat_ack_d;
  logic [15:0] stat_to_q, stat_to_d;

  always_comb begin
    stat_ack_d = stat_ack_q;
    stat_to_d  = stat_to_q;
    if (state_q == ACCESS && state_d == RESPOND) begin
      if (rsp_err_d) begin
        if (stat_to_q != 16'hFFFF) stat_to_d = stat_to_q + 16'd1;
      end else begin
        if (stat_ack_q != 16'hFFFF) stat_ack_d = stat_ack_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ack_q <= '0;
      stat_to_q  <= '0;
    end else begin
      stat_ack_q <= stat_ack_d;
      stat_to_q  <= stat_to_d;
    end
  end

  assign stat_o = {stat_to_q, stat_ack_q};
`else
  assign stat_o = 32'h0;
`endif

endmodule

// File: tb/tb_turf_reg_bridge.sv
// Directed bench for turf_reg_bridge: vector table of bus transactions plus
// hand-written backpressure and mid-access reset sequences.
module tb_turf_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [27:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [7:0]  cmd_tag;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [7:0]  rsp_tag;
  logic        en_o, wr_o, ack_i;
  logic [27:0] adr_o;
  logic [31:0] dat_o, dat_i, stat_o;

  int total = 0;
  int bad   = 0;
  int exp_ack = 0;
  int exp_to  = 0;

  // Bus slave model: acks in the ack_at-th en_o cycle (1 = combinational), 0 = never.
  logic [8:0]  ack_at  = 9'd0;
  logic [8:0]  en_run  = 9'd0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en_o) en_run <= en_run + 9'd1;
    else      en_run <= 9'd0;
  end

  assign ack_i = en_o && (ack_at != 9'd0) && (en_run == ack_at - 9'd1);
  assign dat_i = bus_rdata;

  turf_reg_bridge dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .en_o(en_o), .wr_o(wr_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i), .stat_o(stat_o)
  );

  typedef struct {
    logic        wr;
    logic [27:0] adr;
    logic [31:0] dat;
    logic [7:0]  tag;
    logic [8:0]  ack_at;
    logic [31:0] rdata;
    int          exp_en;
    int          exp_wr;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [27:0] adr, input logic [31:0] dat,
                       input logic [7:0] tag);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_tag   = tag;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Observe the access until rsp_valid; leaves the response pending.
  task automatic collect(input logic [27:0] adr, input int exp_en, input int exp_wr,
                         input logic [31:0] exp_dat, input logic [7:0] exp_tag,
                         input logic exp_err);
    int en_n = 0;
    int wr_n = 0;
    int lat  = 0;
    logic adr_bad = 1'b0;
    logic seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (en_o) begin
        en_n++;
        if (wr_o) wr_n++;
        if (adr_o !== adr) adr_bad = 1'b1;
      end
    end
    chk("rsp_seen", {31'b0, seen}, 32'd1);
    chk("en_cycles", en_n, exp_en);
    chk("wr_cycles", wr_n, exp_wr);
    chk("latency", lat, exp_en + 1);
    chk("adr_stable", {31'b0, adr_bad}, 32'd0);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_tag", {24'b0, rsp_tag}, {24'b0, exp_tag});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    $display("txn tag=%h adr=%h en=%0d wr=%0d lat=%0d rsp_dat=%h err=%b",
             rsp_tag, adr, en_n, wr_n, lat, rsp_dat, rsp_err);
    if (exp_err) exp_to++;
    else         exp_ack++;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    ack_at    = vecs[i].ack_at;
    bus_rdata = vecs[i].rdata;
    issue(vecs[i].wr, vecs[i].adr, vecs[i].dat, vecs[i].tag);
    collect(vecs[i].adr, vecs[i].exp_en, vecs[i].exp_wr, vecs[i].exp_dat,
            vecs[i].tag, vecs[i].exp_err);
    release_rsp();
  endtask

  task automatic chk_stat();
    logic [31:0] exp_stat;
`ifdef TURF_BRIDGE_STATS_EN
    exp_stat = {exp_to[15:0], exp_ack[15:0]};
`else
    exp_stat = 32'h0;
`endif
    chk("stat_o", stat_o, exp_stat);
  endtask

  initial begin
    vecs[0] = '{1'b1, 28'h0000002, 32'hA5A5A5A5, 8'h11, 9'd2,   32'hDEADBEEF, 2,   2, 32'hA5A5A5A5, 1'b0};
    vecs[1] = '{1'b0, 28'h0000000, 32'h0,        8'h22, 9'd2,   32'h54555246, 2,   0, 32'h54555246, 1'b0};
    vecs[2] = '{1'b0, 28'h8000000, 32'h0,        8'h33, 9'd1,   32'hFFFFFFFF, 1,   0, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{1'b0, 28'h0000005, 32'h0,        8'h44, 9'd0,   32'h12345678, 255, 0, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{1'b0, 28'h0000006, 32'h0,        8'h55, 9'd255, 32'h0BADF00D, 255, 0, 32'h0BADF00D, 1'b0};
    vecs[5] = '{1'b1, 28'h0000010, 32'h00001234, 8'h66, 9'd1,   32'h0,        1,   1, 32'h00001234, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_tag = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("cmd_ready_in_rst", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_en_o", {31'b0, en_o}, 32'd0);
    chk("rst_wr_o", {31'b0, wr_o}, 32'd0);
    chk("rst_adr_o", {4'b0, adr_o}, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_rsp_tag", {24'b0, rsp_tag}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_stat", stat_o, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i);
    chk_stat();

    // Response backpressure with a second command waiting.
    ack_at = 9'd2; bus_rdata = 32'hCAFE0001;
    issue(1'b0, 28'h0000123, 32'h0, 8'h77);
    collect(28'h0000123, 2, 0, 32'hCAFE0001, 8'h77, 1'b0);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_adr = 28'h0000456;
    cmd_dat = 32'h600DF00D; cmd_tag = 8'h88;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_dat", rsp_dat, 32'hCAFE0001);
      chk("bp_rsp_tag", {24'b0, rsp_tag}, 32'h77);
    end
    rsp_ready = 1'b1;
    chk("bp_ready_at_hs", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("bp_rsp_dropped", {31'b0, rsp_valid}, 32'd0);
    chk("bp_en_not_yet", {31'b0, en_o}, 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    collect(28'h0000456, 2, 2, 32'h600DF00D, 8'h88, 1'b0);
    release_rsp();

    // Reset in the second ACCESS cycle discards the command.
    ack_at = 9'd0;
    issue(1'b0, 28'h0000777, 32'h0, 8'h99);
    @(negedge clk);
    chk("mr_en_c1", {31'b0, en_o}, 32'd1);
    @(negedge clk);
    chk("mr_en_c2", {31'b0, en_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_en_dropped", {31'b0, en_o}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mr_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    exp_ack = 0; exp_to = 0;
    chk_stat();

    for (int i = 0; i < 4; i++) run_vec(i);
    chk_stat();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
